// File: rtl/key_encoder_16to4.sv
// Sixteen active-low key lines: synchronise, debounce and priority-encode the highest pressed key.
// Each press is presented once on a valid/ack handshake. The key must be released before the next press.
module key_encoder_16to4 #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] inKey,
  input  logic        ack,
  output logic        valid,
  output logic [3:0]  code,
  output logic        multi,
  output logic [7:0]  pressCount,
  output logic [1:0]  dbg_state
);

  // Handshake: valid rises with a new code/multi and holds them until the consumer
  // samples ack=1 while valid is high. valid drops on that same edge. ack is ignored
  // whenever valid is low. code/multi keep their last value after valid falls.

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_VALID    = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t      state, state_d;
  logic [15:0] sync1, sync2;
  logic [15:0] act;
  logic        any;
  logic [3:0]  enc;
  logic [4:0]  ones;
  logic        cnt_done;

  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       cand, cand_d;
  logic [3:0]       code_d;
  logic             multi_d;
  logic             valid_d;
  logic [7:0]       count_d;

  // Two-flop synchroniser. The reset value means "all keys released".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 16'hFFFF;
      sync2 <= 16'hFFFF;
    end else begin
      sync1 <= inKey;
      sync2 <= sync1;
    end
  end

  assign act      = ~sync2;
  assign any      = |act;
  assign cnt_done = (cnt == LAST_CNT);

  // Highest set index wins. The value is meaningless when no key is active.
  always_comb begin
    enc  = 4'd0;
    ones = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (act[i]) begin
        enc  = 4'(i);
        ones = ones + 5'd1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (any) state_d = S_DEBOUNCE;
      end
      S_DEBOUNCE: begin
        if (!any)                         state_d = S_IDLE;
        else if (enc == cand && cnt_done) state_d = S_VALID;
      end
      S_VALID: begin
        if (ack) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!any && cnt_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values. A change of candidate restarts the debounce window.
  always_comb begin
    cnt_d   = cnt;
    cand_d  = cand;
    code_d  = code;
    multi_d = multi;
    valid_d = valid;
    count_d = pressCount;
    case (state)
      S_IDLE: begin
        if (any) begin
          cand_d = enc;
          cnt_d  = '0;
        end
      end
      S_DEBOUNCE: begin
        if (any) begin
          if (enc != cand) begin
            cand_d = enc;
            cnt_d  = '0;
          end else if (cnt_done) begin
            code_d  = cand;
            multi_d = (ones > 5'd1);
            valid_d = 1'b1;
            count_d = pressCount + 8'd1;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      S_VALID: begin
        if (ack) begin
          valid_d = 1'b0;
          cnt_d   = '0;
        end
      end
      S_RELEASE: begin
        if (any)            cnt_d = '0;
        else if (!cnt_done) cnt_d = cnt + 1'b1;
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      cand       <= 4'd0;
      code       <= 4'd0;
      multi      <= 1'b0;
      valid      <= 1'b0;
      pressCount <= 8'd0;
    end else begin
      cnt        <= cnt_d;
      cand       <= cand_d;
      code       <= code_d;
      multi      <= multi_d;
      valid      <= valid_d;
      pressCount <= count_d;
    end
  end

  // Output logic
  always_comb begin
    dbg_state = state;
  end

endmodule

// File: tb/tb_key_encoder_16to4.sv
// Directed bench for key_encoder_16to4 with DEBOUNCE_CYCLES=4: a vector table of presses
// plus hand-written sequences for reset, bounce, held ack, release-in-VALID and counter wrap.
module tb_key_encoder_16to4;

  localparam int D = 4;
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_VALID    = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  logic        clk;
  logic        rst_n;
  logic [15:0] inKey;
  logic        ack;
  logic        valid;
  logic [3:0]  code;
  logic        multi;
  logic [7:0]  pressCount;
  logic [1:0]  dbg_state;

  key_encoder_16to4 #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inKey      (inKey),
    .ack        (ack),
    .valid      (valid),
    .code       (code),
    .multi      (multi),
    .pressCount (pressCount),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_count = 8'd0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  code;
    logic        multi;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a press and check that valid rises exactly after edge D+2.
  task automatic do_press(input logic [15:0] keys, input logic [3:0] exp_code,
                          input logic exp_multi, input string name);
    logic       early;
    logic [3:0] exp_c;
    early = 1'b0;
    exp_q.push_back(exp_code);
    inKey = keys;
    for (int e = 0; e <= D + 2; e++) begin
      tick();
      if (e < D + 2 && valid) early = 1'b1;
    end
    exp_count = exp_count + 8'd1;
    exp_c = exp_q.pop_front();
    check({name, " early_valid"}, 16'(early), 16'd0);
    check({name, " valid"},       16'(valid), 16'd1);
    check({name, " code"},        16'(code), 16'(exp_c));
    check({name, " multi"},       16'(multi), 16'(exp_multi));
    check({name, " count"},       16'(pressCount), 16'(exp_count));
  endtask

  task automatic do_ack(input string name);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check({name, " valid_after_ack"}, 16'(valid), 16'd0);
  endtask

  task automatic do_release(input string name);
    inKey = 16'hFFFF;
    repeat (D + 4) tick();
    check({name, " idle_after_release"}, 16'(dbg_state), 16'(ST_IDLE));
  endtask

  initial begin
    int         pulses;
    logic       prev;
    logic       seen;
    logic [15:0] kv;

    vecs[0] = '{16'hFFDF, 4'd5,  1'b0};
    vecs[1] = '{16'h7FFE, 4'd15, 1'b1};
    vecs[2] = '{16'hFFFE, 4'd0,  1'b0};
    vecs[3] = '{16'h7FFF, 4'd15, 1'b0};
    vecs[4] = '{16'hF0FF, 4'd11, 1'b1};
    vecs[5] = '{16'hFFFC, 4'd1,  1'b1};
    vecs[6] = '{16'hBFFF, 4'd14, 1'b0};
    vecs[7] = '{16'h0000, 4'd15, 1'b1};

    // Reset
    rst_n = 1'b0;
    inKey = 16'hFFFF;
    ack   = 1'b0;
    repeat (3) tick();
    check("reset valid", 16'(valid), 16'd0);
    check("reset code",  16'(code), 16'd0);
    check("reset multi", 16'(multi), 16'd0);
    check("reset count", 16'(pressCount), 16'd0);
    check("reset state", 16'(dbg_state), 16'(ST_IDLE));
    rst_n = 1'b1;
    repeat (2) tick();

    // ack outside VALID is ignored
    ack = 1'b1;
    repeat (3) tick();
    ack = 1'b0;
    check("idle_ack state", 16'(dbg_state), 16'(ST_IDLE));
    check("idle_ack valid", 16'(valid), 16'd0);

    // Vector table
    for (int i = 0; i < 8; i++) begin
      do_press(vecs[i].keys, vecs[i].code, vecs[i].multi, $sformatf("vec%0d", i));
      do_ack($sformatf("vec%0d", i));
      check($sformatf("vec%0d code_held", i), 16'(code), 16'(vecs[i].code));
      do_release($sformatf("vec%0d", i));
    end

    // Key released while VALID: held until ack, then RELEASE needs exactly D edges
    do_press(16'hFEFF, 4'd8, 1'b0, "relvalid");
    inKey = 16'hFFFF;
    repeat (10) tick();
    check("relvalid valid_held", 16'(valid), 16'd1);
    check("relvalid code_held",  16'(code), 16'd8);
    check("relvalid state",      16'(dbg_state), 16'(ST_VALID));
    do_ack("relvalid");
    check("relvalid release_state", 16'(dbg_state), 16'(ST_RELEASE));
    repeat (D - 1) tick();
    check("relvalid still_release", 16'(dbg_state), 16'(ST_RELEASE));
    tick();
    check("relvalid idle", 16'(dbg_state), 16'(ST_IDLE));

    // Bounce shorter than D
    seen  = 1'b0;
    inKey = 16'hFFF7;
    repeat (2) tick();
    inKey = 16'hFFFF;
    repeat (10) begin
      tick();
      if (valid) seen = 1'b1;
    end
    check("bounce no_valid", 16'(seen), 16'd0);
    check("bounce count",    16'(pressCount), 16'(exp_count));
    check("bounce state",    16'(dbg_state), 16'(ST_IDLE));

    // Reset asserted mid-DEBOUNCE
    inKey = 16'hFFFE;
    repeat (4) tick();
    check("rstmid in_debounce", 16'(dbg_state), 16'(ST_DEBOUNCE));
    #2 rst_n = 1'b0;
    #1;
    check("rstmid valid", 16'(valid), 16'd0);
    check("rstmid code",  16'(code), 16'd0);
    check("rstmid count", 16'(pressCount), 16'd0);
    check("rstmid state", 16'(dbg_state), 16'(ST_IDLE));
    exp_count = 8'd0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_press(16'hFFFE, 4'd0, 1'b0, "rstmid fresh");
    do_ack("rstmid fresh");
    do_release("rstmid fresh");

    // Key 9 held 50 cycles with ack held high
    pulses = 0;
    prev   = 1'b0;
    ack    = 1'b1;
    inKey  = 16'hFDFF;
    repeat (50) begin
      tick();
      if (valid && !prev) begin
        pulses++;
        check("heldack code", 16'(code), 16'd9);
      end
      prev = valid;
    end
    inKey = 16'hFFFF;
    repeat (2) begin
      tick();
      if (valid && !prev) pulses++;
      prev = valid;
    end
    inKey = 16'hFDFF;
    repeat (20) begin
      tick();
      if (valid && !prev) pulses++;
      prev = valid;
    end
    check("heldack one_pulse", 16'(pulses), 16'd1);
    inKey = 16'hFFFF;
    repeat (D + 4) begin
      tick();
      if (valid && !prev) pulses++;
      prev = valid;
    end
    inKey = 16'hFDFF;
    repeat (20) begin
      tick();
      if (valid && !prev) pulses++;
      prev = valid;
    end
    check("heldack second_pulse", 16'(pulses), 16'd2);
    exp_count = exp_count + 8'd2;
    check("heldack count", 16'(pressCount), 16'(exp_count));
    ack = 1'b0;
    do_release("heldack");

    // 256 presses wrap pressCount back to its starting value
    for (int i = 0; i < 256; i++) begin
      kv = ~(16'h0001 << (i % 16));
      do_press(kv, 4'(i % 16), 1'b0, $sformatf("wrap%0d", i));
      do_ack("wrap");
      do_release("wrap");
    end
    check("wrap count", 16'(pressCount), 16'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
